// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic elastic pipeline register with valid/ready handshake.
// One parametrised stage replaces the fixed per-stage state structs. It
// supports back-pressure stalls and flushes. SKID=1 adds a second entry so
// in_ready comes straight from a flop, which breaks the combinational ready
// chain between stages.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      kill all held entries and the current input beat
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload (opaque)
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts (low = stall)
//   out_data   registered payload to next stage
//   occupancy  entries held: 0..1 (SKID=0), 0..2 (SKID=1)
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W = 64,
  parameter int                   SKID      = 1,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  // The state encoding equals the entry count, so occupancy, out_valid and
  // the SKID=1 in_ready are all plain bits of the state flop. With SKID=0
  // ST_ONE plays the role of the FULL state.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  logic [1:0]           state, state_nxt;
  logic [PAYLOAD_W-1:0] main_q, skid_q;
  logic                 accept, out_fire;
  logic                 load_main_in, load_main_skid, load_skid;

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A new beat goes straight to the output register when that register is
  // empty or being drained this cycle; otherwise it parks in the skid entry.
  assign load_main_in   = accept & ~flush & ((state == ST_EMPTY) | out_ready);
  assign load_skid      = accept & ~flush & (state == ST_ONE) & ~out_ready;
  assign load_main_skid = out_fire & (state == ST_TWO);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if ((SKID != 0) && accept && !out_ready) state_nxt = ST_TWO;
        else if (out_fire && !accept)            state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (out_fire) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any transfer; a concurrent out_fire is still seen
    // downstream, only the held entries and the incoming beat are dropped.
    if (flush) state_nxt = ST_EMPTY;
  end

  // Outputs
  always_comb begin
    out_valid = (state != ST_EMPTY);
    occupancy = state;
    if (SKID != 0) in_ready = ~state[1];
    else           in_ready = out_ready | (state == ST_EMPTY);
  end

  // Payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (flush)               main_q <= RESET_VAL;
      else if (load_main_in)   main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg, one instance per SKID value.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic        flush1, iv1, ir1, ov1, ordy1;
  logic [63:0] id1, od1;
  logic [1:0]  occ1;
  // SKID=0 instance
  logic        flush0, iv0, ir0, ov0, ordy0;
  logic [63:0] id0, od0;
  logic [1:0]  occ0;

  localparam logic [63:0] RV0 = 64'hDEAD;

  pipe_stage_reg #(.PAYLOAD_W(64), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
    .occupancy(occ1));

  pipe_stage_reg #(.PAYLOAD_W(64), .SKID(0), .RESET_VAL(RV0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0),
    .occupancy(occ0));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q1[$];
  logic [63:0] q0[$];

  initial begin
    rst = 1'b1;
    flush1 = 0; iv1 = 0; ordy1 = 0; id1 = '0;
    flush0 = 0; iv0 = 0; ordy0 = 0; id0 = '0;

    // Reset state
    repeat (2) step();
    chk("rst_ov",   64'(ov1),  64'd0);
    chk("rst_occ",  64'(occ1), 64'd0);
    chk("rst_od",   od1,       64'd0);
    chk("rst_od0",  od0,       RV0);
    rst = 1'b0;
    step();
    chk("ir_after_rst", 64'(ir1), 64'd1);

    // Streaming 1..8, no stall
    ordy1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1'b1; id1 = 64'(i);
      step();
      chk("stream_od",  od1,        64'(i));
      chk("stream_ov",  64'(ov1),   64'd1);
      chk("stream_occ", 64'(occ1),  64'd1);
    end
    iv1 = 1'b0;
    step();
    chk("stream_drain_ov",  64'(ov1),  64'd0);
    chk("stream_drain_occ", 64'(occ1), 64'd0);

    // Stall fill into skid entry
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 64'hA;
    step();
    chk("fill_occ1", 64'(occ1), 64'd1);
    chk("fill_od_a", od1,       64'hA);
    chk("fill_ir1",  64'(ir1),  64'd1);
    id1 = 64'hB;
    step();
    chk("fill_occ2", 64'(occ1), 64'd2);
    chk("fill_ir0",  64'(ir1),  64'd0);
    chk("fill_hold", od1,       64'hA);
    iv1 = 1'b0;
    step();
    chk("stall_od",  od1,       64'hA);
    chk("stall_occ", 64'(occ1), 64'd2);
    chk("stall_ov",  64'(ov1),  64'd1);
    ordy1 = 1'b1;
    chk("release_od_a", od1, 64'hA);
    step();
    chk("release_od_b", od1,       64'hB);
    chk("release_occ",  64'(occ1), 64'd1);
    chk("release_ir",   64'(ir1),  64'd1);
    step();
    chk("release_empty", 64'(ov1), 64'd0);

    // Flush while full, with a valid beat on the input
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 64'hA;
    step();
    id1 = 64'hB;
    step();
    chk("pre_flush_occ", 64'(occ1), 64'd2);
    flush1 = 1'b1; id1 = 64'hC;
    step();
    flush1 = 1'b0; iv1 = 1'b0;
    chk("flush_ov",  64'(ov1),  64'd0);
    chk("flush_occ", 64'(occ1), 64'd0);
    chk("flush_od",  od1,       64'd0);
    chk("flush_ir",  64'(ir1),  64'd1);
    ordy1 = 1'b1;
    step();
    chk("flush_no_c", 64'(ov1), 64'd0);

    // SKID=0 combinational ready
    chk("s0_ir_empty", 64'(ir0), 64'd1);
    iv0 = 1'b1; id0 = 64'h55;
    step();
    chk("s0_ov",  64'(ov0),  64'd1);
    chk("s0_od",  od0,       64'h55);
    chk("s0_occ", 64'(occ0), 64'd1);
    iv0 = 1'b0;
    #1;
    chk("s0_ir_stall", 64'(ir0), 64'd0);
    ordy0 = 1'b1;
    #1;
    chk("s0_ir_pass", 64'(ir0), 64'd1);
    step();
    chk("s0_drain_ov",  64'(ov0),  64'd0);
    chk("s0_drain_occ", 64'(occ0), 64'd0);
    iv0 = 1'b1; id0 = 64'h66;
    step();
    chk("s0_od66", od0, 64'h66);
    flush0 = 1'b1; id0 = 64'h77; ordy0 = 1'b0;
    step();
    flush0 = 1'b0; iv0 = 1'b0;
    chk("s0_flush_ov", 64'(ov0), 64'd0);
    chk("s0_flush_od", od0,      RV0);

    // Reset mid-stream, together with flush
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 64'h11;
    step();
    id1 = 64'h22;
    step();
    rst = 1'b1; flush1 = 1'b1;
    step();
    rst = 1'b0; flush1 = 1'b0; iv1 = 1'b0;
    chk("midrst_occ", 64'(occ1), 64'd0);
    chk("midrst_ov",  64'(ov1),  64'd0);
    chk("midrst_od",  od1,       64'd0);

    // Random traffic on both instances against queue models
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit a1, f1, a0, f0;
      chk("r1_ov",  64'(ov1),  64'(q1.size() != 0));
      chk("r1_occ", 64'(occ1), 64'(q1.size()));
      chk("r1_ir",  64'(ir1),  64'(q1.size() < 2));
      if (q1.size() != 0) chk("r1_od", od1, q1[0]);
      chk("r0_ov",  64'(ov0),  64'(q0.size() != 0));
      chk("r0_occ", 64'(occ0), 64'(q0.size()));
      if (q0.size() != 0) chk("r0_od", od0, q0[0]);

      iv1 = 1'($urandom_range(0, 1)); id1 = {$urandom, $urandom};
      ordy1 = ($urandom_range(0, 2) != 0); flush1 = ($urandom_range(0, 63) == 0);
      iv0 = 1'($urandom_range(0, 1)); id0 = {$urandom, $urandom};
      ordy0 = ($urandom_range(0, 2) != 0); flush0 = ($urandom_range(0, 63) == 0);
      #1;
      chk("r0_ir", 64'(ir0), 64'(ordy0 || q0.size() == 0));

      a1 = iv1 && (q1.size() < 2);
      f1 = ordy1 && (q1.size() != 0);
      if (flush1) q1.delete();
      else begin
        if (f1) void'(q1.pop_front());
        if (a1) q1.push_back(id1);
      end
      a0 = iv0 && (ordy0 || q0.size() == 0);
      f0 = ordy0 && (q0.size() != 0);
      if (flush0) q0.delete();
      else begin
        if (f0) void'(q0.pop_front());
        if (a0) q0.push_back(id0);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
